// File: rtl/add7_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add7_seq_pkg
//  Description : Shared definitions for the multi-cycle 7-bit-slice adder
//                sequencer: slice width, FSM state encoding and the counter
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package add7_seq_pkg;

    localparam int SLICE_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add7_seq_state_t;

    // Width of the slice index counter; never narrower than one bit so the
    // single-slice build still has a legal counter.
    function automatic int idx_width(input int slices);
        return (slices <= 1) ? 1 : $clog2(slices);
    endfunction

endpackage : add7_seq_pkg
`default_nettype wire

// File: rtl/add7_slice.sv
`default_nettype none
// ============================================================================
//  Module      : add7_slice
//  Description : Purely combinational 7-bit carry-lookahead adder slice.
//                Every internal carry is a flat sum of generate/propagate
//                products; the carry out of bit 6 is exported explicitly so
//                the sequencer can chain slices across clock cycles.
//  Ports       : a[6:0], b[6:0], cin -> r[6:0], cout
//  Revision    : 1.0 - initial release
// ============================================================================
module add7_slice
    import add7_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] r,
    output logic               cout
);

    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_carry;   // w_carry[i] is the carry into bit i
    logic               w_prop;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Lookahead: carry into bit i+1 = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        w_carry    = '0;
        w_prop     = 1'b0;
        w_carry[0] = cin;
        for (int i = 0; i < SLICE_W - 1; i++) begin
            w_carry[i+1] = w_g[i];
            w_prop       = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_carry[i+1] = w_carry[i+1] | (w_prop & w_g[j]);
                w_prop       = w_prop & w_p[j];
            end
            w_carry[i+1] = w_carry[i+1] | (w_prop & cin);
        end
    end

    assign r    = w_p ^ w_carry;
    assign cout = w_g[SLICE_W-1] | (w_p[SLICE_W-1] & w_carry[SLICE_W-1]);

endmodule : add7_slice
`default_nettype wire

// File: rtl/add7_chain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : add7_chain_sequencer
//  Description : Multi-cycle wide adder controller. A single 7-bit CLA slice
//                adds W = 7*SLICES-bit operands, LSB slice first, one slice
//                per clock, with the carry registered between cycles.
//  Ports       : clk, rst_n (async, active low)
//                start_valid/start_ready, a[W-1:0], b[W-1:0], cin  (request)
//                op_sub                       (only with ADD7_SEQ_SUB_MODE_EN)
//                result_valid/result_ready, sum[W-1:0], cout       (result)
//                busy                         (high in RUN or DONE)
//  Config      : define ADD7_SEQ_SUB_MODE_EN to add the op_sub input
//                (a - b via ~b and a forced carry-in of 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module add7_chain_sequencer
    import add7_seq_pkg::*;
#(
    parameter int SLICES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [SLICE_W*SLICES-1:0] a,
    input  logic [SLICE_W*SLICES-1:0] b,
    input  logic                      cin,
`ifdef ADD7_SEQ_SUB_MODE_EN
    input  logic                      op_sub,
`endif
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [SLICE_W*SLICES-1:0] sum,
    output logic                      cout,
    output logic                      busy
);

    localparam int W     = SLICE_W * SLICES;
    localparam int IDX_W = idx_width(SLICES);

    add7_seq_state_t    r_state;
    add7_seq_state_t    w_state_next;

    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic               r_c;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_sum;
    logic               r_cout;

    logic [W-1:0]       w_b_in;
    logic               w_cin_in;
    logic [SLICE_W-1:0] w_slice_r;
    logic               w_slice_cout;
    logic [W-1:0]       w_sum_next;
    logic [W-1:0]       w_op_a_shr;
    logic [W-1:0]       w_op_b_shr;
    logic               w_last;
    logic               w_accept;

    // ------------------------------------------------------------------
    // Operand conditioning at accept time
    // ------------------------------------------------------------------
`ifdef ADD7_SEQ_SUB_MODE_EN
    // Two's-complement subtract: a + ~b + 1; cin is ignored when subtracting.
    assign w_b_in   = op_sub ? ~b : b;
    assign w_cin_in = op_sub ? 1'b1 : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    // ------------------------------------------------------------------
    // Shared slice: always looks at the low 7 bits of the shift registers
    // ------------------------------------------------------------------
    add7_slice u_slice (
        .a    (r_op_a[SLICE_W-1:0]),
        .b    (r_op_b[SLICE_W-1:0]),
        .cin  (r_c),
        .r    (w_slice_r),
        .cout (w_slice_cout)
    );

    // Slice results enter the sum at the top and migrate down, so after
    // SLICES steps slice 0's result sits in sum[6:0].
    generate
        if (SLICES == 1) begin : g_single_slice
            assign w_sum_next = w_slice_r;
            assign w_op_a_shr = '0;
            assign w_op_b_shr = '0;
        end else begin : g_multi_slice
            assign w_sum_next = {w_slice_r, r_sum[W-1:SLICE_W]};
            assign w_op_a_shr = {{SLICE_W{1'b0}}, r_op_a[W-1:SLICE_W]};
            assign w_op_b_shr = {{SLICE_W{1'b0}}, r_op_b[W-1:SLICE_W]};
        end
    endgenerate

    assign w_last   = (r_idx == IDX_W'(SLICES - 1));
    assign w_accept = (r_state == IDLE) && start_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_valid)  w_state_next = RUN;
            RUN:     if (w_last)       w_state_next = DONE;
            DONE:    if (result_ready) w_state_next = IDLE;
            default:                   w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE:    start_ready  = 1'b1;
            RUN:     busy         = 1'b1;
            DONE: begin
                result_valid = 1'b1;
                busy         = 1'b1;
            end
            default: start_ready  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, carry, slice index, sum and carry out
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_c    <= 1'b0;
            r_idx  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            r_op_a <= a;
            r_op_b <= w_b_in;
            r_c    <= w_cin_in;
            r_idx  <= '0;
        end else if (r_state == RUN) begin
            r_sum  <= w_sum_next;
            r_op_a <= w_op_a_shr;
            r_op_b <= w_op_b_shr;
            r_c    <= w_slice_cout;
            r_idx  <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_slice_cout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : add7_chain_sequencer
`default_nettype wire
